// File: rtl/stream_accumulator.sv
// rtl/stream_accumulator.sv - windowed stream summer with start-up delay and run/done handshake (optional: STREAM_ACCUMULATOR_SATURATE_EN)
module stream_accumulator #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              running,
    output logic              done,
    input  logic [DATA_W-1:0] in0,
    input  logic [CNT_W-1:0]  delay0,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  iterations,
    output logic [DATA_W-1:0] out0,
    output logic              out0_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t            state_q;
    logic [CNT_W-1:0]  delay_cnt_q;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  iter_q;
    logic [CNT_W-1:0]  samp_cnt_q;
    logic [CNT_W-1:0]  iter_cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] out0_q;
    logic              valid_q;
    logic              running_q;
    logic              done_q;

    logic [DATA_W-1:0] acc_base_d;
    logic [DATA_W-1:0] sum_d;
    logic              last_sample_d;
    logic              last_iter_d;

    // Two's-complement add; clamps to the signed limits when saturation is built in
    function automatic logic [DATA_W-1:0] add_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1])) begin
            s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // Window arithmetic: first sample of each window starts from zero, not the old sum
    always_comb begin
        acc_base_d    = (samp_cnt_q == CNT_ZERO) ? '0 : acc_q;
        sum_d         = add_fn(acc_base_d, in0);
        last_sample_d = (samp_cnt_q == (period_q - CNT_ONE));
        last_iter_d   = (iter_cnt_q == (iter_q - CNT_ONE));
    end

    // Control FSM, counters, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            delay_cnt_q <= '0;
            period_q    <= '0;
            iter_q      <= '0;
            samp_cnt_q  <= '0;
            iter_cnt_q  <= '0;
            acc_q       <= '0;
            out0_q      <= '0;
            valid_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run && (iterations != CNT_ZERO)) begin
                        period_q   <= (period == CNT_ZERO) ? CNT_ONE : period;
                        iter_q     <= iterations;
                        samp_cnt_q <= '0;
                        iter_cnt_q <= '0;
                        acc_q      <= '0;
                        running_q  <= 1'b1;
                        done_q     <= 1'b0;
                        if (delay0 == CNT_ZERO) begin
                            state_q <= S_ACCUM;
                        end else begin
                            delay_cnt_q <= delay0;
                            state_q     <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    delay_cnt_q <= delay_cnt_q - CNT_ONE;
                    if (delay_cnt_q == CNT_ONE) begin
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= sum_d;
                    if (last_sample_d) begin
                        samp_cnt_q <= '0;
                        out0_q     <= sum_d;
                        valid_q    <= 1'b1;
                        if (last_iter_d) begin
                            state_q   <= S_IDLE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            iter_cnt_q <= iter_cnt_q + CNT_ONE;
                        end
                    end else begin
                        samp_cnt_q <= samp_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            endcase
        end
    end

    assign out0       = out0_q;
    assign out0_valid = valid_q;
    assign running    = running_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// tb/tb_stream_accumulator.sv - scoreboard bench for stream_accumulator
module tb_stream_accumulator;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              run;
    logic              running;
    logic              done;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in0_drv;
    logic [CNT_W-1:0]  delay0;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  iterations;
    logic [DATA_W-1:0] out0;
    logic              out0_valid;

    logic              use_dl;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] dl0, dl1, dl2;

    int n_checks;
    int n_errors;
    int cyc;
    int valid_cnt;
    logic [DATA_W-1:0] exp_q[$];
    int                vcyc_q[$];

    stream_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .running    (running),
        .done       (done),
        .in0        (in0),
        .delay0     (delay0),
        .period     (period),
        .iterations (iterations),
        .out0       (out0),
        .out0_valid (out0_valid)
    );

    assign in0 = use_dl ? dl2 : in0_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-deep fixed delay line standing in for the upstream buffer
    always @(posedge clk) begin
        dl0 <= src;
        dl1 <= dl0;
        dl2 <= dl1;
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor: every valid pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (out0_valid === 1'b1) begin
            valid_cnt++;
            vcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {31'd0, out0_valid}, 32'd0);
            end else begin
                check_eq("out0", out0, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int d, input int p, input int it);
        run        = 1'b1;
        delay0     = CNT_W'(d);
        period     = CNT_W'(p);
        iterations = CNT_W'(it);
        tick();
        run = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] v);
        in0_drv = v;
        tick();
    endtask

    int v0;
    int d01, d12;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; valid_cnt = 0;
        rst = 1'b1; run = 1'b0; in0_drv = '0; delay0 = '0; period = '0; iterations = '0;
        use_dl = 1'b0; src = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check_eq("rst_done", {31'd0, done}, 32'd1);
        check_eq("rst_running", {31'd0, running}, 32'd0);
        check_eq("rst_out0", out0, 32'd0);
        check_eq("rst_valid", {31'd0, out0_valid}, 32'd0);

        // basic: 1+2+3+4
        exp_q.push_back(32'd10);
        start_run(0, 4, 1);
        check_eq("basic_running", {31'd0, running}, 32'd1);
        check_eq("basic_done_low", {31'd0, done}, 32'd0);
        feed(1); feed(2); feed(3); feed(4);
        check_eq("basic_done_edge", {31'd0, done}, 32'd1);
        check_eq("basic_running_edge", {31'd0, running}, 32'd0);
        check_eq("basic_valid_edge", {31'd0, out0_valid}, 32'd1);
        repeat (4) tick();
        check_eq("basic_hold", out0, 32'd10);
        check_eq("basic_pulses", valid_cnt, 32'd1);

        // delay alignment through a 3-deep delay line
        use_dl = 1'b1;
        vcyc_q.delete();
        repeat (3) exp_q.push_back(32'd10);
        start_run(4, 2, 3);
        tick();
        src = 32'd5;
        repeat (6) tick();
        src = 32'd0;
        repeat (6) tick();
        check_eq("dl_pulses", vcyc_q.size(), 32'd3);
        if (vcyc_q.size() == 3) begin
            d01 = vcyc_q[1] - vcyc_q[0];
            d12 = vcyc_q[2] - vcyc_q[1];
            check_eq("dl_gap01", d01, 32'd2);
            check_eq("dl_gap12", d12, 32'd2);
        end
        use_dl = 1'b0;

        // iterations = 0 does nothing
        v0 = valid_cnt;
        start_run(0, 4, 0);
        check_eq("it0_done", {31'd0, done}, 32'd1);
        check_eq("it0_running", {31'd0, running}, 32'd0);
        feed(9); feed(9); feed(9); feed(9); feed(9);
        check_eq("it0_pulses", valid_cnt - v0, 32'd0);

        // period = 0 behaves as 1
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd8);
        start_run(0, 0, 2);
        feed(7); feed(8);
        check_eq("p0_done", {31'd0, done}, 32'd1);
        tick();

        // positive overflow
`ifdef STREAM_ACCUMULATOR_SATURATE_EN
        exp_q.push_back(32'h7FFF_FFFF);
        exp_q.push_back(32'h8000_0000);
`else
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h7FFF_FFFF);
`endif
        start_run(0, 2, 1);
        feed(32'h7FFF_FFFF); feed(32'd1);
        // negative overflow
        start_run(0, 2, 1);
        feed(32'h8000_0000); feed(32'hFFFF_FFFF);
        tick();

        // reset on the third sample of a four-sample window
        v0 = valid_cnt;
        start_run(0, 4, 1);
        feed(1); feed(2);
        in0_drv = 32'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_out0", out0, 32'd0);
        check_eq("mrst_done", {31'd0, done}, 32'd1);
        check_eq("mrst_running", {31'd0, running}, 32'd0);
        feed(4); feed(4); feed(4);
        check_eq("mrst_pulses", valid_cnt - v0, 32'd0);
        exp_q.push_back(32'd9);
        start_run(0, 2, 1);
        feed(4); feed(5);
        check_eq("mrst_rerun_done", {31'd0, done}, 32'd1);
        tick();

        // handshake: mid-run run pulse and config change ignored, back-to-back accepted
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd30);
        start_run(1, 3, 2);
        period = 16'd1; iterations = 16'd5; delay0 = 16'd0;
        feed(32'd100);
        feed(1);
        run = 1'b1;
        feed(2);
        run = 1'b0;
        feed(3); feed(4); feed(5); feed(6);
        check_eq("b2b_done_rise", {31'd0, done}, 32'd1);
        start_run(0, 2, 1);
        check_eq("b2b_running", {31'd0, running}, 32'd1);
        feed(10); feed(20);
        repeat (4) tick();
        check_eq("b2b_final_out0", out0, 32'd30);

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Versat functional unit that sits directly downstream of the fixed delay-line buffer and consumes its delayed stream.
- After a configurable start-up delay that covers upstream pipeline fill, it sums `in0` over windows of `PERIOD` samples.
- It emits one sum per window and repeats for `ITERATIONS` windows.
- `run`/`running`/`done` follow the standard Versat unit handshake, so the unit slots into the accelerator alongside the delay buffers.

Parameters:
- DATA_W, 32, width of the input sample and of the accumulated sum.
- CNT_W, 16, width of the delay, period and iteration configuration fields and of their counters.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  single-cycle start pulse; loads configuration and starts a run.
- running  output  1  high while a run is in progress.
- done  output  1  high when idle (after reset and after a completed run).
- in0  input  DATA_W  sample stream, signed two's complement (fed by the delay buffer).
- delay0  input  CNT_W  cycles to wait after `run` before the first sample is taken.
- period  input  CNT_W  samples per window (0 is treated as 1).
- iterations  input  CNT_W  number of windows per run (0 means no windows).
- out0  output  DATA_W  last completed window sum, registered (versat_latency = 1).
- out0_valid  output  1  one-cycle pulse, coincident with `out0` updating to a new sum.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; `out0`=0; `out0_valid`=0; `running`=0; `done`=1.
  - Accumulator and all counters are cleared.
  - Reset wins over `run` in the same cycle and aborts any run in progress; no sum is emitted.
- Configuration latching: `delay0`, `period` and `iterations` are sampled only on the cycle `run`=1 while in IDLE. Changes mid-run are ignored.
- State IDLE: `running`=0, `done`=1.
  - `run`=1 and `iterations`=0 → stay IDLE; `done` stays 1.
  - `run`=1, `iterations`≠0, `delay0`=0 → go to ACCUM.
  - `run`=1, `iterations`≠0, `delay0`≠0 → go to DELAY with delay counter = `delay0`.
- State DELAY: `running`=1, `done`=0.
  - Delay counter decrements each cycle; `in0` is ignored.
  - When the counter reaches 1 → go to ACCUM.
  - Net effect: the first accumulated sample is the `in0` present exactly `delay0`+1 cycles after the `run` edge.
- State ACCUM: `running`=1, `done`=0.
  - Each cycle: acc = acc + `in0` (first sample of a window starts from 0, not from the previous acc); sample counter increments.
  - On the last sample of a window (count = effective `period`):
    - Next edge: `out0` = acc + `in0` and `out0_valid`=1.
    - acc restarts with the next window's first sample on the following cycle; there are no bubbles between windows.
    - The iteration counter increments.
  - After the last window's final sample → IDLE.
  - `done` goes 1 and `running` goes 0 on the same edge that presents the final `out0`/`out0_valid`.
- `run` pulses received while not in IDLE are ignored.
- `out0` holds its value between valid pulses and across runs until overwritten or reset.
- Arithmetic: DATA_W-bit two's-complement add.
  - Without the optional feature, overflow wraps modulo 2^DATA_W.
  - No width growth; any growth is the caller's concern.
- Counters are CNT_W bits. `period` = 2^CNT_W−1 and `iterations` = 2^CNT_W−1 must work without counter overflow; counters compare before incrementing.
- Back-to-back runs: a `run` in the first cycle of IDLE (the cycle `done` rises) is accepted.

Optional Feature:
- Macro: STREAM_ACCUMULATOR_SATURATE_EN.
- When defined: each add saturates to the signed limits.
  - Positive overflow → 2^(DATA_W−1)−1; negative overflow → −2^(DATA_W−1).
  - Saturation applies per add, so an accumulator at max plus a negative sample decreases normally.
- When undefined: plain wrap-around addition as above. No extra logic is generated.

Test Plan:
- Basic: reset, then `run` with `delay0`=0, `period`=4, `iterations`=1, `in0`=1,2,3,4 on the first four sampled cycles → `out0`=10 with a single `out0_valid` pulse; `done` rises on that same edge; `out0` stays 10 afterwards.
- Delay alignment: feed `in0` from a 3-deep fixed delay line whose source is 5,5,5,…, preceded by zeros; `delay0`=4, `period`=2, `iterations`=3 → three valid pulses on consecutive 2-cycle boundaries, each `out0`=10, with no gap between windows.
- Degenerate config: `iterations`=0 → `done` stays 1, `running` stays 0, no `out0_valid`; `period`=0 with `iterations`=2 and `in0`=7,8 → two sums, 7 then 8.
- Overflow: DATA_W=32, `period`=2, `in0`=0x7FFFFFFF then 1 → `out0`=0x80000000 without the macro, 0x7FFFFFFF with STREAM_ACCUMULATOR_SATURATE_EN.
- Reset mid-run: assert `rst` on the 3rd sample of a 4-sample window → no `out0_valid`; `out0`=0, `done`=1, `running`=0 next cycle; a new `run` then completes normally.
- Handshake robustness: pulse `run` mid-run, change `period` mid-run, and issue `run` on the cycle `done` rises → the mid-run pulse and the config change have no effect; the back-to-back run starts with the newly latched configuration.
